vector_mul_sched: RTL and testbench

//  Shares one 32x32 signed multiplier datapath (vector_mul_simple, 2-cycle, no backpressure)

---
 rtl/vector_mul_pkg.sv | 18 +
 rtl/vector_mul_res_fifo.sv | 59 +++++
 rtl/vector_mul_simple.sv | 36 +++
 rtl/vector_mul_sched.sv | 131 +++++++++++++
 tb/tb_vector_mul_sched.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_mul_pkg.sv
// Shared types and constants for the shared-multiplier scheduler and its datapath.
// No logic of its own; latency figures here are consumed by the importing modules.
// Payload id field is sized for up to 2**MAX_ID_W requesters.
package vector_mul_pkg;

    localparam int MUL_LAT  = 2;
    localparam int MAX_ID_W = 8;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [63:0]         result;
    } rsp_entry_t;

endpackage

// File: rtl/vector_mul_res_fifo.sv
// Show-ahead result FIFO holding tagged products.
// Latency 1 cycle push-to-head; no push->pop bypass.
// Backpressure: head held stable until pop_rdy; pushes while full are dropped.
module vector_mul_res_fifo
    import vector_mul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_vld,
    input  rsp_entry_t push_dat,
    input  logic       pop_rdy,
    output logic       head_vld,
    output rsp_entry_t head_dat,
    output logic       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rsp_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign head_vld = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && head_vld;
    assign head_dat = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/vector_mul_simple.sv
// 32x32 signed multiplier, fully pipelined.
// Latency 2 cycles from in_valid_i to out_valid_o.
// No backpressure: one op per cycle accepted, results must be consumed on arrival.
module vector_mul_simple (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    input  logic [31:0] in_a_i,
    input  logic [31:0] in_b_i,
    output logic        out_valid_o,
    output logic [63:0] out_result_o
);

    logic        s1_vld;
    logic [63:0] s1_a;
    logic [63:0] s1_b;

    // Operands are sign-extended up front so the low 64 bits of an unsigned
    // product equal the signed product.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld       <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            out_valid_o  <= 1'b0;
            out_result_o <= '0;
        end else begin
            s1_vld       <= in_valid_i;
            s1_a         <= {{32{in_a_i[31]}}, in_a_i};
            s1_b         <= {{32{in_b_i[31]}}, in_b_i};
            out_valid_o  <= s1_vld;
            out_result_o <= s1_a * s1_b;
        end
    end

endmodule

// File: rtl/vector_mul_sched.sv
// Round-robin scheduler sharing one multiplier among NUM_REQ requesters, tagged in-order responses.
// Latency MUL_LAT+1 cycles from request transfer to rsp_valid_o.
// Backpressure: credits (ops in flight + buffered) gate grants; rsp_ready_i low eventually stalls issue.
module vector_mul_sched #(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_DEPTH = 4,
    parameter  int MUL_LAT    = vector_mul_pkg::MUL_LAT,
    localparam int ID_W       = vector_mul_pkg::id_width(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_a_i,
    input  logic [NUM_REQ*32-1:0] req_b_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [ID_W-1:0]       rsp_id_o,
    output logic [63:0]           rsp_result_o,
    output logic                  busy_o
);
    import vector_mul_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic             issue;
    logic             pop;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic             mul_vld;
    logic [63:0]      mul_res;
    logic [MUL_LAT-1:0] pipe_vld;
    logic [ID_W-1:0]  pipe_id [MUL_LAT];
    rsp_entry_t       push_dat;
    rsp_entry_t       head_dat;
    logic             head_vld;
    logic             fifo_full;

    // Scan starts just after the last winner, so requester NUM_REQ-1 after reset means 0 goes first.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // run keeps grants off while reset is held and for the first cycle after release.
    assign issue       = run && found && (cnt < CNT_W'(FIFO_DEPTH));
    assign req_ready_o = issue ? (NUM_REQ'(1) << win) : '0;
    assign mul_a       = req_a_i[32*win +: 32];
    assign mul_b       = req_b_i[32*win +: 32];
    assign pop         = head_vld && rsp_ready_i;
    assign busy_o      = (cnt != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run <= 1'b0;
            cnt <= '0;
            ptr <= ID_W'(NUM_REQ - 1);
        end else begin
            run <= 1'b1;
            if (issue) ptr <= win;
            case ({issue, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_vld <= '0;
            for (int i = 0; i < MUL_LAT; i++) pipe_id[i] <= '0;
        end else begin
            pipe_vld[0] <= issue;
            pipe_id[0]  <= win;
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    vector_mul_simple u_mul (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (issue),
        .in_a_i       (mul_a),
        .in_b_i       (mul_b),
        .out_valid_o  (mul_vld),
        .out_result_o (mul_res)
    );

    assign push_dat = '{id: MAX_ID_W'(pipe_id[MUL_LAT-1]), result: mul_res};

    vector_mul_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .push_vld (mul_vld),
        .push_dat (push_dat),
        .pop_rdy  (rsp_ready_i),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .full     (fifo_full)
    );

    assign rsp_valid_o  = head_vld;
    assign rsp_id_o     = head_vld ? head_dat.id[ID_W-1:0] : '0;
    assign rsp_result_o = head_vld ? head_dat.result : '0;

    a_tail_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mul_vld == pipe_vld[MUL_LAT-1]);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mul_vld && fifo_full));
    a_id_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        head_vld |-> ((head_dat.id >> ID_W) == '0));

endmodule

// File: tb/tb_vector_mul_sched.sv
// Randomised and directed bench: model predicts grants, credits and response timing;
// a separate monitor pops the scoreboard whenever a response is accepted.
module tb_vector_mul_sched;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [63:0]     rsp_result;
    logic            busy;

    typedef struct {
        int          id;
        logic [63:0] prod;
    } exp_t;

    exp_t        sb[$];
    int          rt[$];
    int          grant_log[$];
    logic [63:0] res_log[$];
    int          checks = 0;
    int          errors = 0;
    int          last_win;
    int          cyc;
    int          rsp_seen;
    logic        last_rsp_vld;

    always #5 clk = ~clk;

    vector_mul_sched #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .busy_o       (busy)
    );

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb2;
        sa  = longint'(signed'(a));
        sb2 = longint'(signed'(b));
        return sa * sb2;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]       = 1'b1;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
    endtask

    task automatic hold_all(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++)
            if (mask[i] && !req_valid[i]) set_req(i, rnd_op(), rnd_op());
    endtask

    // One clock: called at a falling edge with inputs already applied.
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] xfer;
        logic         avail;
        #1;
        exp_rdy = '0;
        if (rt.size() < DEPTH) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (last_win + k) % N;
                if (exp_rdy == '0 && req_valid[idx]) exp_rdy[idx] = 1'b1;
            end
        end
        avail = (rt.size() != 0) && (rt[0] <= cyc);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(rt.size() != 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(avail));
        last_rsp_vld = rsp_valid;
        if (rsp_valid) rsp_seen++;
        xfer = req_valid & exp_rdy;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                sb.push_back('{id: i, prod: ref_mul(req_a[32*i +: 32], req_b[32*i +: 32])});
                rt.push_back(cyc + LAT);
                grant_log.push_back(i);
                last_win = i;
            end
        end
        if (avail && rsp_ready) void'(rt.pop_front());
        cyc++;
        @(negedge clk);
        req_valid = req_valid & ~xfer;
    endtask

    task automatic drain(input string name);
        rsp_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (req_valid == '0 && sb.size() == 0 && rt.size() == 0) break;
            step();
        end
        chk(name, 64'(sb.size() + rt.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid && rsp_ready) begin
                res_log.push_back(rsp_result);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d result 0x%0h, want no response", rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_result", rsp_result, e.prod);
                end
            end
        end
    end

    initial begin : stimulus
        int base;
        int g0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        last_win  = N - 1;
        cyc       = 0;
        rsp_seen  = 0;
        rst_n     = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single op, response three cycles after transfer.
        rsp_ready = 1'b1;
        base = res_log.size();
        set_req(0, 32'd3, 32'hFFFF_FFFB);
        step();
        chk("t1_grant", 64'(grant_log[0]), 64'd0);
        step(); chk("t1_lat1", 64'(last_rsp_vld), 64'd0);
        step(); chk("t1_lat2", 64'(last_rsp_vld), 64'd0);
        step(); chk("t1_lat3", 64'(last_rsp_vld), 64'd1);
        drain("t1_drain");
        chk("t1_result", res_log[base], 64'hFFFF_FFFF_FFFF_FFF1);

        // All four requesting: rotating grants, one response per cycle once filled.
        base = grant_log.size();
        g0   = (last_win + 1) % N;
        repeat (6) begin hold_all(4'b1111); step(); end
        rsp_seen = 0;
        repeat (16) begin hold_all(4'b1111); step(); end
        chk("t2_no_bubble", 64'(rsp_seen), 64'd16);
        for (int j = 0; j < 8; j++)
            chk("t2_order", 64'(grant_log[base + j]), 64'((g0 + j) % N));
        drain("t2_drain");

        // Credits exhaust at FIFO_DEPTH with the consumer stalled.
        rsp_ready = 1'b0;
        base = grant_log.size();
        repeat (10) begin hold_all(4'b0001); step(); end
        chk("t3_xfers", 64'(grant_log.size() - base), 64'(DEPTH));
        rsp_ready = 1'b1;
        repeat (8) begin hold_all(4'b0001); step(); end
        drain("t3_drain");

        // Operand extremes.
        base = res_log.size();
        set_req(2, 32'h8000_0000, 32'h8000_0000); step();
        set_req(2, 32'h7FFF_FFFF, 32'h8000_0000); step();
        set_req(2, 32'h0000_0000, 32'hFFFF_FFFF); step();
        drain("t4_drain");
        chk("t4_min_sq", res_log[base], 64'h4000_0000_0000_0000);
        chk("t4_max_min", res_log[base + 1], 64'hC000_0000_8000_0000);
        chk("t4_zero", res_log[base + 2], 64'h0);

        // Reset with one buffered and two in-flight ops.
        rsp_ready = 1'b0;
        repeat (3) begin hold_all(4'b0001); step(); end
        hold_all(4'b0001);
        #1;
        chk("t5_pre_valid", 64'(rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_req_ready", 64'(req_ready), 64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_rsp_id", 64'(rsp_id), 64'd0);
        chk("t5_rsp_result", rsp_result, 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        sb.delete();
        rt.delete();
        last_win  = N - 1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b1;
        repeat (6) step();

        // Fairness between two persistent requesters.
        base = grant_log.size();
        repeat (8) begin hold_all(4'b1010); step(); end
        for (int j = 0; j < 8; j++)
            chk("t6_alternate", 64'(grant_log[base + j]), (j % 2 == 0) ? 64'd1 : 64'd3);
        drain("t6_drain");

        // Random valid/ready stress.
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, rnd_op(), rnd_op());
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain("t7_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
